rgb_fade_sequencer: RTL

- Generates the three duty-cycle words (R, G, B) that drive the per-colour PWM channel blocks of the RGB LED path.
- Steps continuously around a 6-phase hue wheel at a programmable rate.
- New duty values are committed only on a PWM period boundary reported by the downstream channel, so the LED output never glitches mid-period.
- Sits directly upstream of the RED/GREEN/BLUE PWM channels.

---
 rtl/rgb_pkg.sv | 21 ++
 rtl/rgb_step_prescaler.sv | 32 +++
 rtl/rgb_fade_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared hue-wheel types and duty helpers for the RGB fade path and its PWM channels.
package rgb_pkg;

  localparam int unsigned DUTY_W_DEFAULT = 8;
  localparam int unsigned NUM_PHASES     = 6;

  // Names describe which colour is ramping and in which direction.
  typedef enum logic [2:0] {
    PH_G_UP = 3'd0,
    PH_R_DN = 3'd1,
    PH_B_UP = 3'd2,
    PH_G_DN = 3'd3,
    PH_R_UP = 3'd4,
    PH_B_DN = 3'd5
  } phase_t;

  function automatic int unsigned duty_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/rgb_step_prescaler.sv
// Step-rate prescaler: pulses tick_c once every rate+1 enabled clk cycles.
module rgb_step_prescaler #(
  parameter int unsigned PRESC_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] rate,
  output logic               tick_c
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // >= so a live rate drop below the current count still wraps at once.
  always_comb begin
    tick_c = enable && (cnt_q >= rate);
    cnt_d  = '0;
    if (enable && !tick_c) begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Hue-wheel duty sequencer feeding the R/G/B PWM channels; commits only at PWM period ends.
// Optional build macro RGB_FADE_BRIGHTNESS_EN adds a global brightness scale input.
module rgb_fade_sequencer
  import rgb_pkg::*;
#(
  parameter int unsigned DUTY_W  = DUTY_W_DEFAULT,
  parameter int unsigned PRESC_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PRESC_W-1:0] rate,
  input  logic               period_end,
`ifdef RGB_FADE_BRIGHTNESS_EN
  input  logic [DUTY_W-1:0]  brightness,
`endif
  output logic [DUTY_W-1:0]  duty_r,
  output logic [DUTY_W-1:0]  duty_g,
  output logic [DUTY_W-1:0]  duty_b,
  output logic [2:0]         phase,
  output logic               duty_valid
);

  localparam logic [DUTY_W-1:0] MAX      = DUTY_W'(duty_max(DUTY_W));
  localparam logic [DUTY_W-1:0] LVL_LAST = MAX - DUTY_W'(1);

  logic              tick_c;
  logic              apply_c;
  logic              pending_q,    pending_d;
  logic [DUTY_W-1:0] lvl_q,        lvl_d;
  phase_t            phase_q,      phase_d;
  logic [DUTY_W-1:0] duty_r_q,     duty_r_d;
  logic [DUTY_W-1:0] duty_g_q,     duty_g_d;
  logic [DUTY_W-1:0] duty_b_q,     duty_b_d;
  logic              duty_valid_q, duty_valid_d;
  logic [DUTY_W-1:0] raw_r_c, raw_g_c, raw_b_c;
  logic [DUTY_W-1:0] out_r_c, out_g_c, out_b_c;
  logic [DUTY_W-1:0] rst_r_c;

  rgb_step_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .rate   (rate),
    .tick_c (tick_c)
  );

  assign apply_c = enable && period_end && (pending_q || tick_c);

  // Hue wheel mapping from the post-apply level and phase.
  always_comb begin
    raw_r_c = '0;
    raw_g_c = '0;
    raw_b_c = '0;
    case (phase_d)
      PH_G_UP: begin
        raw_r_c = MAX;
        raw_g_c = lvl_d;
      end
      PH_R_DN: begin
        raw_r_c = MAX - lvl_d;
        raw_g_c = MAX;
      end
      PH_B_UP: begin
        raw_g_c = MAX;
        raw_b_c = lvl_d;
      end
      PH_G_DN: begin
        raw_g_c = MAX - lvl_d;
        raw_b_c = MAX;
      end
      PH_R_UP: begin
        raw_r_c = lvl_d;
        raw_b_c = MAX;
      end
      default: begin
        raw_r_c = MAX;
        raw_b_c = MAX - lvl_d;
      end
    endcase
  end

`ifdef RGB_FADE_BRIGHTNESS_EN
  localparam int unsigned PROD_W = 2 * DUTY_W + 1;

  // (raw * (br+1)) >> DUTY_W, so br == MAX is an exact pass-through.
  function automatic logic [DUTY_W-1:0] scale(input logic [DUTY_W-1:0] raw,
                                              input logic [DUTY_W-1:0] br);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(raw) * (PROD_W'(br) + PROD_W'(1));
    return DUTY_W'(prod >> DUTY_W);
  endfunction

  always_comb begin
    out_r_c = scale(raw_r_c, brightness);
    out_g_c = scale(raw_g_c, brightness);
    out_b_c = scale(raw_b_c, brightness);
    rst_r_c = scale(MAX, brightness);
  end
`else
  always_comb begin
    out_r_c = raw_r_c;
    out_g_c = raw_g_c;
    out_b_c = raw_b_c;
    rst_r_c = MAX;
  end
`endif

  // Pending-tick latch and hue advance; outputs hold unless a step is applied.
  always_comb begin
    pending_d    = pending_q;
    lvl_d        = lvl_q;
    phase_d      = phase_q;
    duty_r_d     = duty_r_q;
    duty_g_d     = duty_g_q;
    duty_b_d     = duty_b_q;
    duty_valid_d = 1'b0;

    if (!enable || apply_c) begin
      pending_d = 1'b0;
    end else if (tick_c) begin
      pending_d = 1'b1;
    end

    if (apply_c) begin
      if (lvl_q == LVL_LAST) begin
        lvl_d = '0;
        if (32'(phase_q) == NUM_PHASES - 1) begin
          phase_d = PH_G_UP;
        end else begin
          phase_d = phase_t'(phase_q + 3'd1);
        end
      end else begin
        lvl_d = lvl_q + DUTY_W'(1);
      end
      duty_r_d     = out_r_c;
      duty_g_d     = out_g_c;
      duty_b_d     = out_b_c;
      duty_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= 1'b0;
      lvl_q        <= '0;
      phase_q      <= PH_G_UP;
      duty_r_q     <= rst_r_c;
      duty_g_q     <= '0;
      duty_b_q     <= '0;
      duty_valid_q <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      lvl_q        <= lvl_d;
      phase_q      <= phase_d;
      duty_r_q     <= duty_r_d;
      duty_g_q     <= duty_g_d;
      duty_b_q     <= duty_b_d;
      duty_valid_q <= duty_valid_d;
    end
  end

  assign duty_r     = duty_r_q;
  assign duty_g     = duty_g_q;
  assign duty_b     = duty_b_q;
  assign phase      = 3'(phase_q);
  assign duty_valid = duty_valid_q;

endmodule
